// File: rtl/central_alarme_if.sv
// Sensor/keypad inputs and status outputs of the alarm controller.
// The bench drives through master; the controller consumes through slave.
interface central_alarme_if;
   logic       porta_i;
   logic       janela_i;
   logic       movimento_i;
   logic       armar_i;
   logic       desarmar_i;
   logic       alarme_o;
   logic [2:0] estado_o;
   logic [2:0] zonas_o;

   modport master (
      output porta_i, janela_i, movimento_i, armar_i, desarmar_i,
      input  alarme_o, estado_o, zonas_o
   );

   modport slave (
      input  porta_i, janela_i, movimento_i, armar_i, desarmar_i,
      output alarme_o, estado_o, zonas_o
   );
endinterface

// File: rtl/central_alarme.sv
// Alarm controller: exit delay, armed watch, entry delay on the door zone,
// timed siren, sticky zone memory. One shared 8-bit down-counter times all delays.
module central_alarme #(
   parameter int EXIT_DELAY  = 10,
   parameter int ENTRY_DELAY = 8,
   parameter int SIREN_TIME  = 20
) (
   input logic            clk_i,
   input logic            rst_i,
   central_alarme_if.slave bus
);
   typedef enum logic [2:0] {
      DESARMADO = 3'd0,
      SAIDA     = 3'd1,
      ARMADO    = 3'd2,
      ENTRADA   = 3'd3,
      DISPARADO = 3'd4
   } state_e;

   localparam logic [7:0] EXIT_LD  = 8'(EXIT_DELAY - 1);
   localparam logic [7:0] ENTRY_LD = 8'(ENTRY_DELAY - 1);
   localparam logic [7:0] SIREN_LD = 8'(SIREN_TIME - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] zonas_q, zonas_d;
   logic [2:0] zone_act;
   logic       imm;
   logic       expired;

   assign zone_act = {bus.movimento_i, bus.janela_i, bus.porta_i};
   assign imm      = bus.janela_i | bus.movimento_i;
   assign expired  = (cnt_q == 8'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= DESARMADO;
         cnt_q   <= 8'd0;
         zonas_q <= 3'b000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         zonas_q <= zonas_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = expired ? 8'd0 : cnt_q - 8'd1;
      zonas_d = zonas_q;
      // Zones are recorded on every watched edge, even the one that disarms.
      if (state_q == ARMADO || state_q == ENTRADA || state_q == DISPARADO)
         zonas_d = zonas_q | zone_act;
      case (state_q)
         DESARMADO: begin
            cnt_d = 8'd0;
            if (bus.armar_i && !bus.desarmar_i) begin
               state_d = SAIDA;
               cnt_d   = EXIT_LD;
               zonas_d = 3'b000;
            end
         end
         SAIDA: begin
            if (bus.desarmar_i)  begin state_d = DESARMADO; cnt_d = 8'd0; end
            else if (expired)    state_d = ARMADO;
         end
         ARMADO: begin
            cnt_d = 8'd0;
            if (bus.desarmar_i)   state_d = DESARMADO;
            else if (imm)         begin state_d = DISPARADO; cnt_d = SIREN_LD; end
            else if (bus.porta_i) begin state_d = ENTRADA;   cnt_d = ENTRY_LD; end
         end
         ENTRADA: begin
            if (bus.desarmar_i)       begin state_d = DESARMADO; cnt_d = 8'd0; end
            else if (imm || expired)  begin state_d = DISPARADO; cnt_d = SIREN_LD; end
         end
         DISPARADO: begin
            if (bus.desarmar_i)  begin state_d = DESARMADO; cnt_d = 8'd0; end
            else if (expired)    state_d = ARMADO;
         end
         default: begin
            state_d = DESARMADO;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign bus.estado_o = state_q;
   assign bus.alarme_o = (state_q == DISPARADO);
   assign bus.zonas_o  = zonas_q;
endmodule

// File: tb/tb_central_alarme.sv
// Randomized + directed bench for central_alarme; a cycle-level reference model
// pushes expected outputs into a queue that a negedge monitor drains and compares.
module tb_central_alarme;
   localparam int EX = 10;
   localparam int EN = 8;
   localparam int SI = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   central_alarme_if bus ();

   central_alarme #(.EXIT_DELAY(EX), .ENTRY_DELAY(EN), .SIREN_TIME(SI)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );

   typedef struct packed {
      logic [2:0] st;
      logic       al;
      logic [2:0] z;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: mode number, cycles spent in current mode, zone memory.
   int m_st = 0;
   int m_el = 0;
   int m_z  = 0;

   function automatic exp_t cur_exp();
      exp_t e;
      e.st = 3'(m_st);
      e.al = (m_st == 4);
      e.z  = 3'(m_z);
      return e;
   endfunction

   task automatic model_reset();
      m_st = 0; m_el = 0; m_z = 0;
   endtask

   task automatic model_step(input bit a, input bit d, input bit p, input bit j, input bit mv);
      int ns;
      int ne;
      ns = m_st;
      ne = m_el + 1;
      if (m_st >= 2 && m_st <= 4) m_z = m_z | (mv << 2) | (j << 1) | p;
      if (m_st != 0 && d) begin
         ns = 0;
      end else begin
         case (m_st)
            0: if (a && !d) begin ns = 1; m_z = 0; end
            1: if (m_el == EX) ns = 2;
            2: if (j || mv) ns = 4; else if (p) ns = 3;
            3: if (j || mv || m_el == EN) ns = 4;
            4: if (m_el == SI) ns = 2;
            default: ns = 0;
         endcase
      end
      if (ns != m_st) ne = 1;
      m_st = ns;
      m_el = ne;
   endtask

   task automatic cmp(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp_v);
      end
   endtask

   // Monitor: the DUT presents a new status every cycle; check it mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp("estado", int'(bus.estado_o), int'(e.st));
         cmp("alarme", int'(bus.alarme_o), int'(e.al));
         cmp("zonas",  int'(bus.zonas_o),  int'(e.z));
      end
   end

   // Called just after a negedge: drive inputs, clock once, push the expectation.
   task automatic step(input bit a, input bit d, input bit p, input bit j, input bit mv);
      bus.armar_i = a; bus.desarmar_i = d;
      bus.porta_i = p; bus.janela_i = j; bus.movimento_i = mv;
      @(posedge clk);
      if (!rst) model_step(a, d, p, j, mv);
      q.push_back(cur_exp());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic arm_to_armado();
      step(1, 0, 0, 0, 0);
      idle(EX);
   endtask

   initial begin
      bus.armar_i = 0; bus.desarmar_i = 0;
      bus.porta_i = 0; bus.janela_i = 0; bus.movimento_i = 0;
      model_reset();
      // Reset state, held across a couple of edges with inputs active.
      q.push_back(cur_exp());
      @(negedge clk);
      bus.armar_i = 1; bus.porta_i = 1;
      step(1, 0, 1, 1, 1);
      @(posedge clk); #2 rst = 0;
      @(negedge clk);

      // Exit delay with door/window pulses ignored, then armed.
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 1);
      idle(EX);

      // Door opened one cycle: entry delay, siren, back to armed.
      step(0, 0, 1, 0, 0);
      idle(EN + SI + 2);

      // Door, then disarm on the 5th entry cycle.
      step(0, 1, 0, 0, 0);
      arm_to_armado();
      step(0, 0, 1, 0, 0);
      idle(4);
      step(0, 1, 0, 0, 0);
      idle(3);

      // Door and motion together: immediate trigger, zones 101.
      arm_to_armado();
      step(0, 0, 1, 0, 1);
      idle(3);
      // Arm+disarm together during siren, then a fresh arm clears zones.
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(2);
      step(0, 1, 0, 0, 0);

      // Sensor held through siren end re-triggers.
      arm_to_armado();
      for (int i = 0; i < SI + 4; i++) step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);

      // Async reset mid-siren, between edges.
      arm_to_armado();
      step(0, 0, 0, 0, 1);
      idle(5);
      @(posedge clk);
      #2 rst = 1;
      model_reset();
      q.delete();
      q.push_back(cur_exp());
      @(negedge clk);
      step(1, 0, 1, 1, 1);
      rst = 0;
      step(1, 0, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit a, d, p, j, mv;
         a  = ($urandom_range(0, 99) < 8);
         d  = ($urandom_range(0, 99) < 3);
         p  = ($urandom_range(0, 99) < 6);
         j  = ($urandom_range(0, 99) < 3);
         mv = ($urandom_range(0, 99) < 3);
         step(a, d, p, j, mv);
      end

      @(negedge clk);
      cmp("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/central_alarme.md
CENTRAL_ALARME -- requirements
Module: central_alarme

Interface
REQ-001 Parameter EXIT_DELAY, default 10: exit-delay length in clock cycles, legal range 1..255.
REQ-002 Parameter ENTRY_DELAY, default 8: entry-delay length in clock cycles, legal range 1..255.
REQ-003 Parameter SIREN_TIME, default 20: siren-on duration in clock cycles, legal range 1..255.
REQ-004 CLK  input  1  the single clock for all sequential logic; rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 PORTA  input  1  door sensor; 1 = open; delayed zone.
REQ-007 JANELA  input  1  window sensor; 1 = open; immediate zone.
REQ-008 MOVIMENTO  input  1  motion sensor; 1 = motion; immediate zone.
REQ-009 ARMAR  input  1  arm request; sampled on each CLK rising edge.
REQ-010 DESARMAR  input  1  disarm request; sampled on each CLK rising edge.
REQ-011 ALARME  output  1  siren drive; 1 = sounding.
REQ-012 ESTADO  output  3  current state: 0 DESARMADO, 1 SAIDA, 2 ARMADO, 3 ENTRADA, 4 DISPARADO.
REQ-013 ZONAS  output  3  sticky zone memory: bit0 PORTA, bit1 JANELA, bit2 MOVIMENTO.

Function
REQ-014 All inputs SHALL be sampled synchronously on the CLK rising edge; all outputs SHALL be registered or decoded from registers only, with no combinational input-to-output path.
REQ-015 The block SHALL use one 8-bit down-counter; on entry to any timed state it SHALL load (delay - 1), decrement once per cycle, and leave the state on the edge where it equals 0, so the timed state is visible for exactly the delay number of cycles.
REQ-016 DESARMADO: ARMAR=1 with DESARMAR=0 SHALL go to SAIDA and clear ZONAS to 000; ARMAR=1 with DESARMAR=1 SHALL stay in DESARMADO; the sensors SHALL be ignored.
REQ-017 SAIDA: the sensors SHALL be ignored; on expiry of EXIT_DELAY the block SHALL go to ARMADO.
REQ-018 ARMADO, JANELA or MOVIMENTO = 1: the block SHALL go to DISPARADO on the same edge.
REQ-019 ARMADO, only PORTA = 1: the block SHALL go to ENTRADA.
REQ-020 ARMADO, simultaneous zones: an immediate zone SHALL take priority over PORTA, giving DISPARADO.
REQ-021 ENTRADA, expiry of ENTRY_DELAY: the block SHALL go to DISPARADO.
REQ-022 ENTRADA, JANELA or MOVIMENTO = 1: the block SHALL go to DISPARADO immediately.
REQ-023 DISPARADO: ALARME SHALL be 1 for exactly SIREN_TIME cycles, then the block SHALL return to ARMADO with ALARME=0.
REQ-024 Sensors still active after the return to ARMADO SHALL re-trigger per REQ-018/REQ-019.
REQ-025 DESARMAR=1 in SAIDA, ARMADO, ENTRADA or DISPARADO SHALL go to DESARMADO on that edge, with priority over all other conditions, including simultaneous ARMAR and counter expiry.
REQ-026 ARMAR SHALL be ignored in every state except DESARMADO.
REQ-027 ALARME SHALL equal 1 exactly when ESTADO=4.
REQ-028 Latency: a triggering sensor sampled at edge k SHALL give ESTADO=4 and ALARME=1 immediately after edge k.
REQ-029 ZONAS bit n SHALL be set on any edge where zone n is active while the state is ARMADO, ENTRADA or DISPARADO.
REQ-030 ZONAS bits SHALL never clear except by reset or an accepted ARMAR.
REQ-031 Unused ESTADO encodings 5..7 SHALL recover to DESARMADO on the next edge.

Reset
REQ-032 RESET=1 SHALL immediately, without waiting for CLK, force ESTADO=0, ALARME=0, ZONAS=000 and counter=0.
REQ-033 While RESET=1 all inputs SHALL be ignored; after RESET falls, the first rising edge SHALL be evaluated normally from DESARMADO.

Verification
REQ-034 The bench SHALL cover: ARMAR pulse -> ESTADO=1 for exactly 10 cycles, then 2; PORTA/JANELA pulses during SAIDA -> no state change, ZONAS=000.
REQ-035 The bench SHALL cover: ARMADO, PORTA=1 for one cycle -> ESTADO=3 for 8 cycles, then 4 with ALARME=1 for 20 cycles, then ESTADO=2, ALARME=0, ZONAS=001.
REQ-036 The bench SHALL cover: ARMADO, PORTA=1, then DESARMAR on the 5th ENTRADA cycle -> ESTADO=0 next edge, ALARME never 1, ZONAS=001 held.
REQ-037 The bench SHALL cover: ARMADO, PORTA=1 and MOVIMENTO=1 on the same edge -> ESTADO=4 and ALARME=1 after that edge, ZONAS=101.
REQ-038 The bench SHALL cover: DISPARADO, ARMAR=1 and DESARMAR=1 together -> ESTADO=0, ALARME=0; a following ARMAR clears ZONAS to 000.
REQ-039 The bench SHALL cover: RESET asserted mid-DISPARADO between clock edges -> ALARME=0, ESTADO=0, ZONAS=000 before the next edge.
